// File: rtl/native_stream_pkg.sv
// Shared definitions for the native stream FIFO: default widths, a
// constant-friendly clog2 and the helper that decodes the FWFT mode string.
package native_stream_pkg;

  localparam int DefaultDataWidth  = 32;
  localparam int DefaultTidWidth   = 8;
  localparam int DefaultTdestWidth = 8;
  localparam int DefaultDepth      = 16;

  // Ceiling log2, usable in parameter/localparam elaboration.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // The mode string arrives packed in a 64-bit vector; only "true" or
  // "TRUE" select first-word-fall-through, anything else is standard read.
  function automatic bit is_fwft(input logic [63:0] mode);
    return (mode == 64'("true")) || (mode == 64'("TRUE"));
  endfunction

endpackage

// File: rtl/native_stream_fifo_mem.sv
// Simple dual-port entry storage: synchronous write, asynchronous read.
module native_stream_fifo_mem #(
  parameter int Width     = 49,
  parameter int Depth     = 16,
  parameter int AddrWidth = 4
) (
  input  logic                 aclk,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [Width-1:0]     wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [Width-1:0]     rdata
);

  logic [Width-1:0] storage [Depth];

  // Store one packed entry per accepted write; contents need no reset.
  always_ff @(posedge aclk) begin
    if (we) storage[waddr] <= wdata;
  end

  assign rdata = storage[raddr];

endmodule

// File: rtl/native_stream_fifo.sv
// Native stream FIFO with wrap-bit pointers, occupancy and almost-full flag.
// Read side is FWFT or registered depending on FirstWordFallThrough.
// Optional sticky overflow/underflow flags: define NATIVE_STREAM_FIFO_ERR_EN.
module native_stream_fifo
  import native_stream_pkg::*;
#(
  parameter int          STDataWidth          = DefaultDataWidth,
  parameter int          TidWidth             = DefaultTidWidth,
  parameter int          TdestWidth           = DefaultTdestWidth,
  parameter int          Depth                = DefaultDepth,
  parameter int          AlmostFullThr        = Depth - 2,
  parameter logic [63:0] FirstWordFallThrough = 64'("true")
) (
  input  logic                      aclk,
  input  logic                      rst,
  input  logic [TidWidth-1:0]       s_native_tid,
  input  logic [TdestWidth-1:0]     s_native_tdest,
  input  logic [STDataWidth-1:0]    s_native_tdata,
  input  logic                      s_native_tlast,
  input  logic                      s_native_tvalid,
  output logic                      s_native_tready,
  output logic [TidWidth-1:0]       m_native_tid,
  output logic [TdestWidth-1:0]     m_native_tdest,
  output logic [STDataWidth-1:0]    m_native_tdata,
  output logic                      m_native_tlast,
  output logic                      m_native_tvalid,
  input  logic                      m_native_tready,
  output logic [clog2(Depth):0]     occupancy,
  output logic                      almost_full
`ifdef NATIVE_STREAM_FIFO_ERR_EN
  ,
  output logic                      overflow_err,
  output logic                      underflow_err
`endif
);

  localparam int AddrWidth  = clog2(Depth);
  localparam int EntryWidth = TidWidth + TdestWidth + STDataWidth + 1;
  localparam bit Fwft       = is_fwft(FirstWordFallThrough);
  localparam logic [AddrWidth:0] AfThr  = (AddrWidth + 1)'(AlmostFullThr);
  localparam logic [AddrWidth:0] PtrOne = {{AddrWidth{1'b0}}, 1'b1};

  logic [AddrWidth:0]  wr_ptr;
  logic [AddrWidth:0]  rd_ptr;
  logic [AddrWidth:0]  count;
  logic                full;
  logic                empty;
  logic                wr_en;
  logic                rd_en;
  logic [EntryWidth-1:0] wr_entry;
  logic [EntryWidth-1:0] rd_entry;
  logic [EntryWidth-1:0] out_entry;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AddrWidth-1:0] == rd_ptr[AddrWidth-1:0]) &&
                 (wr_ptr[AddrWidth] != rd_ptr[AddrWidth]);

  assign s_native_tready = !full && !rst;
  assign m_native_tvalid = !empty && !rst;
  assign wr_en           = s_native_tvalid && s_native_tready;
  assign rd_en           = m_native_tvalid && m_native_tready;
  assign occupancy       = count;
  assign almost_full     = !rst && (count >= AfThr);
  assign wr_entry        = {s_native_tid, s_native_tdest, s_native_tdata, s_native_tlast};

  // Advance the wrap-bit pointers on each handshake; they roll over modulo 2*Depth.
  always_ff @(posedge aclk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PtrOne;
      if (rd_en) rd_ptr <= rd_ptr + PtrOne;
    end
  end

  // Track entry count: up on write-only, down on read-only, hold otherwise.
  always_ff @(posedge aclk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count <= count + PtrOne;
        2'b01:   count <= count - PtrOne;
        default: count <= count;
      endcase
    end
  end

  native_stream_fifo_mem #(
    .Width     (EntryWidth),
    .Depth     (Depth),
    .AddrWidth (AddrWidth)
  ) u_mem (
    .aclk  (aclk),
    .we    (wr_en),
    .waddr (wr_ptr[AddrWidth-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AddrWidth-1:0]),
    .rdata (rd_entry)
  );

  if (Fwft) begin : g_fwft
    assign out_entry = rd_entry;
  end else begin : g_std
    logic [EntryWidth-1:0] out_q;

    // Capture the head entry on a read handshake and hold it until the next read.
    always_ff @(posedge aclk) begin
      if (rst) out_q <= '0;
      else if (rd_en) out_q <= rd_entry;
    end

    assign out_entry = out_q;
  end

  assign {m_native_tid, m_native_tdest, m_native_tdata, m_native_tlast} = out_entry;

`ifdef NATIVE_STREAM_FIFO_ERR_EN
  // Sticky flags for writes attempted while full and reads attempted while empty.
  always_ff @(posedge aclk) begin
    if (rst) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (s_native_tvalid && full)  overflow_err  <= 1'b1;
      if (m_native_tready && empty) underflow_err <= 1'b1;
    end
  end
`else
  // Error flags are not built in this configuration.
`endif

endmodule

// File: tb/tb_native_stream_fifo.sv
// Self-checking bench: one FWFT and one standard-mode FIFO (Depth 4) share
// the same stimulus; a queue-based model predicts occupancy, flags and data.
module tb_native_stream_fifo;

  localparam int Depth = 4;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        rst;
  logic [7:0]  s_tid, s_tdest;
  logic [31:0] s_tdata;
  logic        s_tlast, s_tvalid, m_tready;

  logic        f_s_tready, f_m_tvalid, f_tlast, f_af;
  logic [7:0]  f_tid, f_tdest;
  logic [31:0] f_tdata;
  logic [2:0]  f_occ;
  logic        d_s_tready, d_m_tvalid, d_tlast, d_af;
  logic [7:0]  d_tid, d_tdest;
  logic [31:0] d_tdata;
  logic [2:0]  d_occ;
`ifdef NATIVE_STREAM_FIFO_ERR_EN
  logic f_ovf, f_udf, d_ovf, d_udf;
`endif

  logic [48:0] f_entry, d_entry;
  assign f_entry = {f_tid, f_tdest, f_tdata, f_tlast};
  assign d_entry = {d_tid, d_tdest, d_tdata, d_tlast};

  native_stream_fifo #(.Depth(Depth), .FirstWordFallThrough(64'("true"))) dut_fwft (
    .aclk(aclk), .rst(rst),
    .s_native_tid(s_tid), .s_native_tdest(s_tdest), .s_native_tdata(s_tdata),
    .s_native_tlast(s_tlast), .s_native_tvalid(s_tvalid), .s_native_tready(f_s_tready),
    .m_native_tid(f_tid), .m_native_tdest(f_tdest), .m_native_tdata(f_tdata),
    .m_native_tlast(f_tlast), .m_native_tvalid(f_m_tvalid), .m_native_tready(m_tready),
    .occupancy(f_occ), .almost_full(f_af)
`ifdef NATIVE_STREAM_FIFO_ERR_EN
    , .overflow_err(f_ovf), .underflow_err(f_udf)
`endif
  );

  native_stream_fifo #(.Depth(Depth), .FirstWordFallThrough(64'("false"))) dut_std (
    .aclk(aclk), .rst(rst),
    .s_native_tid(s_tid), .s_native_tdest(s_tdest), .s_native_tdata(s_tdata),
    .s_native_tlast(s_tlast), .s_native_tvalid(s_tvalid), .s_native_tready(d_s_tready),
    .m_native_tid(d_tid), .m_native_tdest(d_tdest), .m_native_tdata(d_tdata),
    .m_native_tlast(d_tlast), .m_native_tvalid(d_m_tvalid), .m_native_tready(m_tready),
    .occupancy(d_occ), .almost_full(d_af)
`ifdef NATIVE_STREAM_FIFO_ERR_EN
    , .overflow_err(d_ovf), .underflow_err(d_udf)
`endif
  );

  // Reference model state
  logic [48:0] q[$];
  logic [48:0] std_reg;
  logic [48:0] last_pop;
  bit          popped;
  logic [48:0] words[20];
  int          total = 0;
  int          bad = 0;

  function automatic logic [48:0] rand_entry();
    return {8'($urandom), 8'($urandom), 32'($urandom), 1'($urandom)};
  endfunction

  // Set the shared inputs, then let combinational outputs settle.
  task automatic drive(input bit v, input logic [48:0] e, input bit r);
    s_tvalid = v;
    {s_tid, s_tdest, s_tdata, s_tlast} = e;
    m_tready = r;
    #1;
  endtask

  // Advance one clock and update the model from the handshake rules.
  task automatic tick();
    bit wr, rd;
    logic [48:0] e;
    e  = {s_tid, s_tdest, s_tdata, s_tlast};
    wr = s_tvalid && (q.size() < Depth) && !rst;
    rd = m_tready && (q.size() > 0) && !rst;
    @(posedge aclk);
    popped = 0;
    if (rst) begin
      q.delete();
      std_reg = '0;
    end else begin
      if (rd) begin
        last_pop = q.pop_front();
        std_reg  = last_pop;
        popped   = 1;
      end
      if (wr) q.push_back(e);
    end
    @(negedge aclk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, '0, 0);
    tick();
    tick();
    total++; if (f_occ !== 3'd0) begin bad++; $display("[TB] FAIL reset_occ: got %0d expected 0", f_occ); end
    total++; if (d_occ !== 3'd0) begin bad++; $display("[TB] FAIL reset_occ_std: got %0d expected 0", d_occ); end
    total++; if (f_s_tready !== 1'b0) begin bad++; $display("[TB] FAIL reset_tready: got %b expected 0", f_s_tready); end
    total++; if (f_m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tvalid: got %b expected 0", f_m_tvalid); end
    total++; if (f_af !== 1'b0) begin bad++; $display("[TB] FAIL reset_af: got %b expected 0", f_af); end
    total++; if (d_entry !== 49'h0) begin bad++; $display("[TB] FAIL reset_std_reg: got %h expected 0", d_entry); end
    rst = 1'b0;
    drive(0, '0, 0);
    total++; if (f_s_tready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_tready: got %b expected 1", f_s_tready); end
    total++; if (f_m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_tvalid: got %b expected 0", f_m_tvalid); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      words[i] = rand_entry();
      drive(1, words[i], 0);
      tick();
      total++; if (f_occ !== 3'(i + 1)) begin bad++; $display("[TB] FAIL fill_occ: got %0d expected %0d", f_occ, i + 1); end
      total++; if (f_af !== (i + 1 >= 2)) begin bad++; $display("[TB] FAIL fill_af: got %b expected %b", f_af, (i + 1 >= 2)); end
      total++; if (f_s_tready !== (i + 1 < 4)) begin bad++; $display("[TB] FAIL fill_tready: got %b expected %b", f_s_tready, (i + 1 < 4)); end
      total++; if (f_entry !== words[0]) begin bad++; $display("[TB] FAIL fill_head: got %h expected %h", f_entry, words[0]); end
    end
    drive(1, rand_entry(), 0);
    total++; if (f_s_tready !== 1'b0) begin bad++; $display("[TB] FAIL full_tready: got %b expected 0", f_s_tready); end
    tick();
    total++; if (f_occ !== 3'd4) begin bad++; $display("[TB] FAIL fifth_write_occ: got %0d expected 4", f_occ); end
    total++; if (d_occ !== 3'd4) begin bad++; $display("[TB] FAIL fifth_write_occ_std: got %0d expected 4", d_occ); end
    total++; if (f_entry !== words[0]) begin bad++; $display("[TB] FAIL fifth_write_head: got %h expected %h", f_entry, words[0]); end
`ifdef NATIVE_STREAM_FIFO_ERR_EN
    total++; if (f_ovf !== 1'b1) begin bad++; $display("[TB] FAIL overflow_flag: got %b expected 1", f_ovf); end
`endif
  endtask

  task automatic test_full_rw();
    drive(1, rand_entry(), 1);
    total++; if (f_entry !== words[0]) begin bad++; $display("[TB] FAIL full_rw_read: got %h expected %h", f_entry, words[0]); end
    tick();
    total++; if (f_occ !== 3'd3) begin bad++; $display("[TB] FAIL full_rw_occ: got %0d expected 3", f_occ); end
    total++; if (d_entry !== words[0]) begin bad++; $display("[TB] FAIL full_rw_std: got %h expected %h", d_entry, words[0]); end
    total++; if (f_s_tready !== 1'b1) begin bad++; $display("[TB] FAIL full_rw_tready: got %b expected 1", f_s_tready); end
    for (int k = 1; k < 4; k++) begin
      drive(0, '0, 1);
      total++; if (f_entry !== words[k]) begin bad++; $display("[TB] FAIL drain_fwft: got %h expected %h", f_entry, words[k]); end
      tick();
      total++; if (d_entry !== words[k]) begin bad++; $display("[TB] FAIL drain_std: got %h expected %h", d_entry, words[k]); end
    end
    total++; if (f_m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL drained_tvalid: got %b expected 0", f_m_tvalid); end
    total++; if (f_occ !== 3'd0) begin bad++; $display("[TB] FAIL drained_occ: got %0d expected 0", f_occ); end
  endtask

  task automatic test_empty_rw();
    logic [48:0] x;
    x = rand_entry();
    drive(1, x, 1);
    tick();
    total++; if (f_m_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL empty_rw_tvalid: got %b expected 1", f_m_tvalid); end
    total++; if (f_entry !== x) begin bad++; $display("[TB] FAIL empty_rw_data: got %h expected %h", f_entry, x); end
    total++; if (f_occ !== 3'd1) begin bad++; $display("[TB] FAIL empty_rw_occ: got %0d expected 1", f_occ); end
    total++; if (d_entry !== words[3]) begin bad++; $display("[TB] FAIL empty_rw_std_hold: got %h expected %h", d_entry, words[3]); end
    drive(0, '0, 1);
    tick();
    total++; if (d_entry !== x) begin bad++; $display("[TB] FAIL empty_rw_std_read: got %h expected %h", d_entry, x); end
  endtask

  task automatic test_standard();
    logic [48:0] p, r;
    p = rand_entry();
    r = rand_entry();
    drive(1, p, 0); tick();
    drive(1, r, 0); tick();
    total++; if (d_entry !== std_reg) begin bad++; $display("[TB] FAIL std_before_read: got %h expected %h", d_entry, std_reg); end
    drive(0, '0, 1); tick();
    total++; if (d_entry !== p) begin bad++; $display("[TB] FAIL std_after_read: got %h expected %h", d_entry, p); end
    drive(0, '0, 0); tick();
    total++; if (d_entry !== p) begin bad++; $display("[TB] FAIL std_hold: got %h expected %h", d_entry, p); end
    drive(0, '0, 1); tick();
    total++; if (d_entry !== r) begin bad++; $display("[TB] FAIL std_second_read: got %h expected %h", d_entry, r); end
  endtask

  task automatic test_stream();
    int idx_in = 0;
    int got = 0;
    int cycles = 0;
    bit v, r, will_read;
    for (int i = 0; i < 20; i++) words[i] = rand_entry();
    while (got < 20 && cycles < 500) begin
      v = (idx_in < 20) && ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 3) != 0);
      drive(v, v ? words[idx_in] : rand_entry(), r);
      total++; if (f_occ !== 3'(q.size())) begin bad++; $display("[TB] FAIL stream_occ: got %0d expected %0d", f_occ, q.size()); end
      total++; if (f_s_tready !== (q.size() < Depth)) begin bad++; $display("[TB] FAIL stream_tready: got %b expected %b", f_s_tready, (q.size() < Depth)); end
      total++; if (f_af !== (q.size() >= 2)) begin bad++; $display("[TB] FAIL stream_af: got %b expected %b", f_af, (q.size() >= 2)); end
      will_read = r && (q.size() > 0);
      if (will_read) begin
        total++; if (f_entry !== words[got]) begin bad++; $display("[TB] FAIL stream_fwft_order: got %h expected %h", f_entry, words[got]); end
      end
      if (v && q.size() < Depth) idx_in++;
      tick();
      if (popped) begin
        total++; if (d_entry !== words[got]) begin bad++; $display("[TB] FAIL stream_std_order: got %h expected %h", d_entry, words[got]); end
        got++;
      end
      cycles++;
    end
    total++; if (got != 20) begin bad++; $display("[TB] FAIL stream_timeout: got %0d words expected 20", got); end
    total++; if (f_m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL stream_end_empty: got %b expected 0", f_m_tvalid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1, rand_entry(), 0);
      tick();
    end
    total++; if (f_occ !== 3'd3) begin bad++; $display("[TB] FAIL mid_pre_occ: got %0d expected 3", f_occ); end
    rst = 1'b1;
    drive(0, '0, 0);
    tick();
    rst = 1'b0;
    drive(0, '0, 0);
    total++; if (f_occ !== 3'd0) begin bad++; $display("[TB] FAIL mid_occ: got %0d expected 0", f_occ); end
    total++; if (f_m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL mid_tvalid: got %b expected 0", f_m_tvalid); end
    total++; if (d_occ !== 3'd0) begin bad++; $display("[TB] FAIL mid_occ_std: got %0d expected 0", d_occ); end
`ifdef NATIVE_STREAM_FIFO_ERR_EN
    total++; if (f_udf !== 1'b0) begin bad++; $display("[TB] FAIL mid_udf_cleared: got %b expected 0", f_udf); end
`endif
    drive(0, '0, 1);
    tick();
    total++; if (f_occ !== 3'd0) begin bad++; $display("[TB] FAIL mid_read_occ: got %0d expected 0", f_occ); end
`ifdef NATIVE_STREAM_FIFO_ERR_EN
    total++; if (f_udf !== 1'b1) begin bad++; $display("[TB] FAIL underflow_flag: got %b expected 1", f_udf); end
    total++; if (d_udf !== 1'b1) begin bad++; $display("[TB] FAIL underflow_flag_std: got %b expected 1", d_udf); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    {s_tid, s_tdest, s_tdata, s_tlast} = '0;
    std_reg = '0;
    last_pop = '0;
    popped = 0;
    #1;
    $display("[TB] starting native_stream_fifo bench");
    test_reset();
    test_fill();
    test_full_rw();
    test_empty_rw();
    test_standard();
    test_stream();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/native_stream_fifo.md
NATIVE_STREAM_FIFO -- requirements
Module: native_stream_fifo

Interface
REQ-001 Parameter STDataWidth, default 32, tdata width in bits.
REQ-002 Parameter TidWidth, default 8, tid width in bits.
REQ-003 Parameter TdestWidth, default 8, tdest width in bits.
REQ-004 Parameter Depth, default 16, entry count; power of two, at least 2.
REQ-005 Parameter AlmostFullThr, default Depth-2, occupancy at or above which almost_full is asserted.
REQ-006 Parameter FirstWordFallThrough, default "true"; "true"/"TRUE" selects FWFT read, any other value selects standard read.
REQ-007 aclk  in  1  the single clock; all state updates on its rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 s_native_tid/tdest/tdata/tlast  in  TidWidth/TdestWidth/STDataWidth/1  write-side fields.
REQ-010 s_native_tvalid  in  1  write request.
REQ-011 s_native_tready  out  1  equals !full and !rst.
REQ-012 m_native_tid/tdest/tdata/tlast  out  TidWidth/TdestWidth/STDataWidth/1  read-side fields.
REQ-013 m_native_tvalid  out  1  equals !empty and !rst.
REQ-014 m_native_tready  in  1  read request; it removes the head entry.
REQ-015 occupancy  out  clog2(Depth)+1  current entry count.
REQ-016 almost_full  out  1  occupancy >= AlmostFullThr.

Function
REQ-017 A write shall occur when s_native_tvalid && s_native_tready; all four fields are stored as one entry.
REQ-018 A read shall occur when m_native_tvalid && m_native_tready.
REQ-019 The pointers shall be clog2(Depth)+1 bits with a wrap bit:
- empty when the pointers are equal;
- full when the index bits are equal and the wrap bits differ;
- the pointers wrap modulo 2*Depth.
REQ-020 occupancy shall be incremented on a write-only cycle, decremented on a read-only cycle, and unchanged on a simultaneous read and write.
REQ-021 When full, a write shall be refused even if a read occurs in the same cycle; s_native_tready rises in the cycle after the read.
REQ-022 When empty, a simultaneous write shall be accepted and the read ignored.
REQ-023 In FWFT mode, the m_native_* fields shall present the head entry combinationally from storage; latency is 1 cycle (written at edge N, m_native_tvalid is high after edge N).
REQ-024 In standard mode, the m_native_* fields shall be registered, loaded on a read handshake, and valid from the edge following the handshake until the next read.
REQ-025 Data order shall be strictly preserved; no entry is duplicated or dropped when the handshakes are obeyed.
REQ-026 A write attempt while s_native_tready is low shall not alter any state; a read attempt while empty shall not alter any state.

Reset
REQ-027 While rst is high, the following shall hold:
- the pointers and occupancy are 0;
- s_native_tready, m_native_tvalid and almost_full are 0;
- the standard-mode output register is 0;
- storage contents are don't-care.
REQ-028 Reset asserted mid-transfer shall discard all entries in the same edge; the first cycle after deassertion behaves as empty.

Configuration
REQ-029 Macro NATIVE_STREAM_FIFO_ERR_EN, when defined, shall add two outputs, overflow_err and underflow_err, 1 bit each:
- overflow_err is a sticky flag, set by a write attempt while full;
- underflow_err is a sticky flag, set by a read attempt while empty;
- both are cleared only by rst.
REQ-030 When NATIVE_STREAM_FIFO_ERR_EN is undefined, those ports and their logic shall be absent, and behaviour is otherwise identical.

Structure
REQ-031 A shared package, native_stream_pkg, shall hold the clog2 function, the default width constants and the FWFT string-compare helper.
REQ-032 Storage shall be a sub-module, native_stream_fifo_mem: simple dual-port, synchronous write, asynchronous read, width TidWidth+TdestWidth+STDataWidth+1.

Verification
REQ-033 Depth=4, FWFT; write A,B,C,D back to back, m_native_tready=0:
- occupancy reaches 4;
- s_native_tready goes 0 after the 4th edge;
- almost_full is 1 from occupancy 2;
- a 5th write is rejected.
REQ-034 Full FIFO with a simultaneous read and write: the read returns A, the write is refused, and occupancy becomes 3.
REQ-035 Empty FIFO; write X with m_native_tready=1 in the same cycle: X is stored, and next cycle m_native_tvalid=1 and tdata=X.
REQ-036 Continuous stream of 20 words with random valid/ready:
- output equals input order, including tlast/tid/tdest;
- pointers wrap at least twice.
REQ-037 Standard mode: after a read handshake at edge N, tdata equals the head entry from edge N+1.
REQ-038 rst pulse with 3 entries stored, followed by a read, with NATIVE_STREAM_FIFO_ERR_EN defined:
- after the rst pulse, occupancy=0 and m_native_tvalid=0;
- the read then sets underflow_err=1.
